// File: rtl/gf4_sched_pkg.sv
// Shared types for the GF(2^2) scale scheduler.
// Optional feature macro: GF_SCL_POW_EN (per-request repeat count).
package gf4_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // GF(2^2) element, polynomial basis
  typedef logic [1:0] gf4_t;

  // Number of scale steps applied to an accepted operand
  typedef logic [1:0] pow_t;

  // Repeat count used when the per-request count is not built in
  localparam pow_t POW_FIXED = 2'd1;

endpackage

// File: rtl/gf4_scl_unit.sv
// Combinational GF(2^2) scale: s(a) = {a1^a0, a1}.
// Shared by all requesters; the scheduler feeds it the accumulator.
module gf4_scl_unit
  import gf4_sched_pkg::*;
(
  input  gf4_t a,
  output gf4_t y
);

  assign y = {a[1] ^ a[0], a[1]};

endmodule

// File: rtl/gf4_scl_sched.sv
// Round-robin scheduler feeding a single shared GF(2^2) scale unit.
// Optional feature macro: GF_SCL_POW_EN adds req_pow (repeat count 0..3
// per requester); without it every operand is scaled exactly once.
//
// state | meaning
// IDLE  | arbitrating; one-hot req_ready to first valid requester from rr_ptr
// RUN   | applying scale to acc once per edge, cnt counts down to 1
// DONE  | result held on out_data/out_id until out_ready
module gf4_scl_sched
  import gf4_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_data,
`ifdef GF_SCL_POW_EN
  input  logic [2*NREQ-1:0] req_pow,
`endif
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [1:0]        out_data,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready,
  output logic              busy
);

  state_e          state_q, state_d;
  gf4_t            acc_q, acc_d;
  pow_t            cnt_q, cnt_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  rr_q, rr_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  cand;
  gf4_t            sel_data;
  pow_t            sel_pow;
  gf4_t            scl_y;

  gf4_scl_unit u_scl (
    .a (acc_q),
    .y (scl_y)
  );

  // Search upward from rr_ptr with wrap; IDW-bit addition gives the wrap for free
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = rr_q + IDW'(k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Operand and repeat count of the requester currently being offered the grant
  always_comb begin
    sel_data = req_data[{grant_idx, 1'b0} +: 2];
`ifdef GF_SCL_POW_EN
    sel_pow  = req_pow[{grant_idx, 1'b0} +: 2];
`else
    sel_pow  = POW_FIXED;
`endif
  end

  // Grant only in IDLE; rst_n gating keeps ready low while reset is held
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          acc_d   = sel_data;
          cnt_d   = sel_pow;
          id_d    = grant_idx;
          rr_d    = grant_idx + IDW'(1);
          state_d = (sel_pow == 2'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        acc_d = scl_y;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_gf4_scl_sched.sv
// Scoreboard bench for gf4_scl_sched (NREQ=4). Works with or without
// GF_SCL_POW_EN defined.
module tb_gf4_scl_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [2*NREQ-1:0] req_data;
  logic [2*NREQ-1:0] req_pow;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [1:0]        out_data;
  logic [IDW-1:0]    out_id;
  logic              out_ready;
  logic              busy;

  always #5 clk = ~clk;

  gf4_scl_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef GF_SCL_POW_EN
    .req_pow   (req_pow),
`endif
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
  );

  typedef struct {
    int         id;
    logic [1:0] data;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          due = 0;
  int          rr_m = 0;
  logic        m_busy = 1'b0;
  logic        acc_seen = 1'b0;
  logic        keep_valid = 1'b0;
  logic [NREQ-1:0] acc_flag = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] scl1(input logic [1:0] a);
    case (a)
      2'b00:   return 2'b00;
      2'b01:   return 2'b10;
      2'b10:   return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] scl_n(input logic [1:0] a, input int n);
    logic [1:0] r;
    r = a;
    for (int k = 0; k < n; k++) r = scl1(r);
    return r;
  endfunction

  function automatic int pow_of(input int i);
`ifdef GF_SCL_POW_EN
    return int'(req_pow[2*i +: 2]);
`else
    return 1;
`endif
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge rst_n) begin
    sb.delete();
    m_busy   = 1'b0;
    rr_m     = 0;
    acc_flag = '0;
  end

  // Reference model: checks handshakes and outputs once per cycle, mid-period
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_ov;
      logic [NREQ-1:0] exp_rdy;
      int g;
      int p;
      exp_ov = m_busy && (cyc >= due);
      chk("busy", busy, m_busy);
      chk("out_valid", out_valid, exp_ov);
      if (!m_busy) begin
        g = rr_pick(req_valid, rr_m);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        if (g >= 0) begin
          exp_t e;
          p = pow_of(g);
          e.id   = g;
          e.data = scl_n(req_data[2*g +: 2], p);
          sb.push_back(e);
          grant_log.push_back(g);
          due      = cyc + 1 + p;
          m_busy   = 1'b1;
          rr_m     = (g + 1) % NREQ;
          acc_flag[g] = 1'b1;
          acc_seen = 1'b1;
        end
      end else begin
        chk("req_ready_busy", req_ready, '0);
        if (exp_ov) begin
          chk("sb_nonempty", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            chk("out_data", out_data, sb[0].data);
            chk("out_id", out_id, sb[0].id);
            if (out_ready) begin
              void'(sb.pop_front());
              m_busy = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (!keep_valid) req_valid = req_valid & ~acc_flag;
    acc_flag = '0;
  endtask

  task automatic wait_accept(input string tag);
    for (int k = 0; k < 40 && !acc_seen; k++) step();
    chk(tag, acc_seen, 1'b1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 60 && (m_busy || req_valid != '0); k++) step();
    chk(tag, m_busy, 1'b0);
  endtask

  task automatic put_req(input int i, input logic [1:0] d, input logic [1:0] p);
    req_data[2*i +: 2] = d;
    req_pow[2*i +: 2]  = p;
    req_valid[i]       = 1'b1;
  endtask

  initial begin
    int exp_order[5];
    req_valid = '0;
    req_data  = '0;
    req_pow   = '0;
    out_ready = 1'b0;

    // Reset state with requests present and clock running
    #12;
    req_valid = '1;
    #1;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 2'b00);
    chk("rst_out_id", out_id, '0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin with all requesters held valid
    out_ready  = 1'b1;
    req_data   = 8'b11_10_01_01;
    req_pow    = 8'b01_10_00_11;
    grant_log.delete();
    keep_valid = 1'b1;
    req_valid  = '1;
    for (int k = 0; k < 80 && grant_log.size() < 5; k++) step();
    keep_valid = 1'b0;
    req_valid  = '0;
    chk("rr_count", grant_log.size() >= 5, 1'b1);
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      chk($sformatf("rr_order%0d", i), grant_log[i], exp_order[i]);
    drain("drain_rr");

    // Single request: requester 2, operand 01
    acc_seen = 1'b0;
    put_req(2, 2'b01, 2'd1);
    wait_accept("acc_single");
    drain("drain_single");

    // Every repeat count with operand 01, then zero operand
    for (int p = 0; p < 4; p++) begin
      acc_seen = 1'b0;
      put_req(0, 2'b01, p[1:0]);
      wait_accept("acc_pow");
      drain("drain_pow");
    end
    for (int p = 0; p < 4; p++) begin
      acc_seen = 1'b0;
      put_req(3, 2'b00, p[1:0]);
      wait_accept("acc_zero");
      drain("drain_zero");
    end

    // Backpressure held in DONE
    out_ready = 1'b0;
    acc_seen  = 1'b0;
    put_req(1, 2'b11, 2'd2);
    wait_accept("acc_bp");
    for (int k = 0; k < 10 && !out_valid; k++) step();
    chk("bp_reach_done", out_valid, 1'b1);
    req_valid = 4'b1101;
    repeat (5) step();
    req_valid = '0;
    out_ready = 1'b1;
    drain("drain_bp");

    // Random traffic, random backpressure
    for (int n = 0; n < 60; n++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          put_req(i, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    drain("drain_rand");

    // Reset asserted while the transaction is in RUN
    for (int k = 0; k < 3; k++) step();
    acc_seen = 1'b0;
    put_req(2, 2'b11, 2'd3);
    wait_accept("acc_rst");
`ifdef GF_SCL_POW_EN
    step();
`endif
    #1;
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("midrun_out_valid", out_valid, 1'b0);
    chk("midrun_busy", busy, 1'b0);
    chk("midrun_req_ready", req_ready, '0);
    repeat (2) @(posedge clk);
    #1;
    grant_log.delete();
    acc_seen = 1'b0;
    acc_flag = '0;
    rst_n = 1'b1;
    wait_accept("acc_after_rst");
    chk("first_grant_after_rst", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    req_valid = '0;
    drain("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
